// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic conflict monitor: lamp states, fault causes and FSM states.
package traffic_pkg;

    typedef enum logic [1:0] {
        LAMP_RED = 2'd0,
        LAMP_YEL = 2'd1,
        LAMP_GRN = 2'd2,
        LAMP_BAD = 2'd3
    } lamp_e;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_CONFLICT  = 3'd1;
    localparam logic [2:0] FC_INVALID   = 3'd2;
    localparam logic [2:0] FC_SEQUENCE  = 3'd3;
    localparam logic [2:0] FC_SHORT_YEL = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEED  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Exactly one lit lamp is a valid aspect; dark or multiple lamps is BAD.
    function automatic lamp_e decode_lamps(input logic r, input logic y, input logic g);
        lamp_e l;
        case ({r, y, g})
            3'b100:  l = LAMP_RED;
            3'b010:  l = LAMP_YEL;
            3'b001:  l = LAMP_GRN;
            default: l = LAMP_BAD;
        endcase
        return l;
    endfunction

    function automatic logic legal_step(input lamp_e from_l, input lamp_e to_l);
        return ((from_l == LAMP_GRN) && (to_l == LAMP_YEL)) ||
               ((from_l == LAMP_YEL) && (to_l == LAMP_RED)) ||
               ((from_l == LAMP_RED) && (to_l == LAMP_GRN));
    endfunction

endpackage

// File: rtl/traffic_conflict_monitor_lamp_filter.sv
// Decodes one approach's lamp drives and accepts a state only after it has
// been stable for GLITCH_CYCLES consecutive samples.
module lamp_filter
    import traffic_pkg::*;
#(
    parameter int unsigned GLITCH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lamp_r,
    input  logic       lamp_y,
    input  logic       lamp_g,
    output logic [1:0] state,
    output logic       valid
);

    localparam logic [3:0] RUN_MAX = 4'(GLITCH_CYCLES);

    lamp_e      raw;
    lamp_e      cand_q, cand_d;
    lamp_e      acc_q, acc_d;
    logic [3:0] run_q, run_d;
    logic       valid_q, valid_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        raw     = decode_lamps(lamp_r, lamp_y, lamp_g);
        cand_d  = raw;
        acc_d   = acc_q;
        valid_d = valid_q;
        if (raw == cand_q) begin
            run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
        end else begin
            run_d = 4'd1;
        end
        if (run_d >= RUN_MAX) begin
            acc_d   = raw;
            valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q  <= LAMP_RED;
            acc_q   <= LAMP_RED;
            run_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            acc_q   <= acc_d;
            run_q   <= run_d;
            valid_q <= valid_d;
        end
    end

    assign state = acc_q;
    assign valid = valid_q;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Two-approach signal conflict monitor: filters lamp drives, checks conflicts,
// lamp validity, aspect sequence and yellow duration, and latches the first fault.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter logic [32:0] FINAL_VALUE   = 33'd500_000_000,
    parameter int unsigned GLITCH_CYCLES = 4,
    parameter int unsigned MIN_YELLOW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       R_a,
    input  logic       Y_a,
    input  logic       G_a,
    input  logic       R_b,
    input  logic       Y_b,
    input  logic       G_b,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_red,
    output logic       ok
);

    localparam logic [3:0] MIN_Y   = 4'(MIN_YELLOW);
    localparam logic [3:0] YEL_SAT = 4'd15;

    logic [1:0]  acc_a_raw, acc_b_raw;
    logic        valid_a, valid_b;
    lamp_e       acc_a, acc_b;

    logic [32:0] pre_q, pre_d;
    logic        tick;
    logic [3:0]  ycnt_a_q, ycnt_a_d, ycnt_b_q, ycnt_b_d;
    logic [1:0]  state_q, state_d;
    lamp_e       prev_a_q, prev_a_d, prev_b_q, prev_b_d;
    logic [2:0]  code_q, code_d;
    logic        flash_q, flash_d;

    logic [2:0]  detect;
    logic        clr_ok;

    lamp_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_filter_a (
        .clk    (clk),
        .reset  (reset),
        .lamp_r (R_a),
        .lamp_y (Y_a),
        .lamp_g (G_a),
        .state  (acc_a_raw),
        .valid  (valid_a)
    );

    lamp_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_filter_b (
        .clk    (clk),
        .reset  (reset),
        .lamp_r (R_b),
        .lamp_y (Y_b),
        .lamp_g (G_b),
        .state  (acc_b_raw),
        .valid  (valid_b)
    );

    assign acc_a = lamp_e'(acc_a_raw);
    assign acc_b = lamp_e'(acc_b_raw);

    assign tick  = (pre_q == FINAL_VALUE - 33'd1);
    assign pre_d = tick ? 33'd0 : pre_q + 33'd1;

    always_comb begin
        ycnt_a_d = 4'd0;
        ycnt_b_d = 4'd0;
        if (acc_a == LAMP_YEL) begin
            ycnt_a_d = (tick && ycnt_a_q != YEL_SAT) ? ycnt_a_q + 4'd1 : ycnt_a_q;
        end
        if (acc_b == LAMP_YEL) begin
            ycnt_b_d = (tick && ycnt_b_q != YEL_SAT) ? ycnt_b_q + 4'd1 : ycnt_b_q;
        end
    end

    // Lowest-numbered cause wins when several are seen in the same cycle.
    always_comb begin
        detect = FC_NONE;
        if (acc_a != LAMP_RED && acc_b != LAMP_RED) begin
            detect = FC_CONFLICT;
        end else if (acc_a == LAMP_BAD || acc_b == LAMP_BAD) begin
            detect = FC_INVALID;
        end else if ((acc_a != prev_a_q && !legal_step(prev_a_q, acc_a)) ||
                     (acc_b != prev_b_q && !legal_step(prev_b_q, acc_b))) begin
            detect = FC_SEQUENCE;
        end else if ((prev_a_q == LAMP_YEL && acc_a == LAMP_RED && ycnt_a_q < MIN_Y) ||
                     (prev_b_q == LAMP_YEL && acc_b == LAMP_RED && ycnt_b_q < MIN_Y)) begin
            detect = FC_SHORT_YEL;
        end
    end

    // Clearing looks at the unfiltered lamps so an operator sees immediate effect.
    assign clr_ok = (decode_lamps(R_a, Y_a, G_a) == LAMP_RED) &&
                    (decode_lamps(R_b, Y_b, G_b) == LAMP_RED);

    always_comb begin
        state_d  = state_q;
        prev_a_d = prev_a_q;
        prev_b_d = prev_b_q;
        code_d   = code_q;
        flash_d  = flash_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SEED;
            end
            ST_SEED: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    if (valid_a) prev_a_d = acc_a;
                    if (valid_b) prev_b_d = acc_b;
                    if (valid_a && valid_b) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (detect != FC_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = detect;
                end else begin
                    prev_a_d = acc_a;
                    prev_b_d = acc_b;
                end
            end
            ST_FAULT: begin
                if (fault_clr && clr_ok) begin
                    state_d = ST_SEED;
                    code_d  = FC_NONE;
                    flash_d = 1'b0;
                end else if (tick) begin
                    flash_d = ~flash_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q    <= 33'd0;
            ycnt_a_q <= 4'd0;
            ycnt_b_q <= 4'd0;
            state_q  <= ST_IDLE;
            prev_a_q <= LAMP_RED;
            prev_b_q <= LAMP_RED;
            code_q   <= FC_NONE;
            flash_q  <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            ycnt_a_q <= ycnt_a_d;
            ycnt_b_q <= ycnt_b_d;
            state_q  <= state_d;
            prev_a_q <= prev_a_d;
            prev_b_q <= prev_b_d;
            code_q   <= code_d;
            flash_q  <= flash_d;
        end
    end

    assign fault      = (state_q == ST_FAULT);
    assign ok         = (state_q == ST_RUN);
    assign fault_code = code_q;
    assign flash_red  = flash_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench: a cycle-level reference model predicts every output word,
// a negedge monitor compares the DUT against the queued predictions.
module tb_traffic_conflict_monitor;

    localparam int FV = 10;
    localparam int G  = 4;
    localparam int MY = 2;

    localparam int L_RED = 0;
    localparam int L_YEL = 1;
    localparam int L_GRN = 2;
    localparam int L_BAD = 3;
    localparam int L_NONE = -1;

    typedef enum int {M_IDLE, M_SEED, M_RUN, M_FAULT} mstate_t;

    logic clk = 1'b0;
    logic rst_n, en, clr;
    logic ra, ya, ga, rb, yb, gb;
    logic fault, flash_red, ok;
    logic [2:0] fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] exp_q[$];

    traffic_conflict_monitor #(
        .FINAL_VALUE   (33'd10),
        .GLITCH_CYCLES (G),
        .MIN_YELLOW    (MY)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .enable     (en),
        .R_a        (ra),
        .Y_a        (ya),
        .G_a        (ga),
        .R_b        (rb),
        .Y_b        (yb),
        .G_b        (gb),
        .fault_clr  (clr),
        .fault      (fault),
        .fault_code (fault_code),
        .flash_red  (flash_red),
        .ok         (ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    mstate_t     m_st;
    int          m_code;
    bit          m_flash;
    int unsigned edges;
    int          acc[2];
    int          prev[2];
    int          ycnt[2];
    int          hist[2][$];

    function automatic int decode(input logic r, input logic y, input logic g);
        if ((int'(r) + int'(y) + int'(g)) != 1) return L_BAD;
        if (r) return L_RED;
        if (y) return L_YEL;
        return L_GRN;
    endfunction

    function automatic bit legal(input int f, input int t);
        return (f == L_GRN && t == L_YEL) || (f == L_YEL && t == L_RED) || (f == L_RED && t == L_GRN);
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_code = 0; m_flash = 0; edges = 0;
        for (int i = 0; i < 2; i++) begin
            acc[i] = L_NONE; prev[i] = L_RED; ycnt[i] = 0;
            hist[i].delete();
        end
    endtask

    task automatic model_step();
        int  raw[2];
        int  c;
        bit  tick;
        raw[0] = decode(ra, ya, ga);
        raw[1] = decode(rb, yb, gb);
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick = ((edges % FV) == FV - 1);
        c = 0;
        for (int i = 0; i < 2; i++)
            if (prev[i] == L_YEL && acc[i] == L_RED && ycnt[i] < MY) c = 4;
        for (int i = 0; i < 2; i++)
            if (acc[i] != prev[i] && !legal(prev[i], acc[i])) c = 3;
        if (acc[0] == L_BAD || acc[1] == L_BAD) c = 2;
        if (acc[0] != L_RED && acc[1] != L_RED) c = 1;
        case (m_st)
            M_IDLE: if (en) m_st = M_SEED;
            M_SEED: begin
                if (!en) m_st = M_IDLE;
                else begin
                    for (int i = 0; i < 2; i++) if (acc[i] != L_NONE) prev[i] = acc[i];
                    if (acc[0] != L_NONE && acc[1] != L_NONE) m_st = M_RUN;
                end
            end
            M_RUN: begin
                if (!en) m_st = M_IDLE;
                else if (c != 0) begin m_st = M_FAULT; m_code = c; end
                else begin prev[0] = acc[0]; prev[1] = acc[1]; end
            end
            default: begin
                if (clr && raw[0] == L_RED && raw[1] == L_RED) begin
                    m_st = M_SEED; m_code = 0; m_flash = 0;
                end else if (tick) m_flash = !m_flash;
            end
        endcase
        for (int i = 0; i < 2; i++) begin
            if (acc[i] != L_YEL) ycnt[i] = 0;
            else if (tick && ycnt[i] < 15) ycnt[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            bit same;
            hist[i].push_back(raw[i]);
            if (hist[i].size() > G) void'(hist[i].pop_front());
            same = (hist[i].size() == G);
            foreach (hist[i][k]) if (hist[i][k] != raw[i]) same = 0;
            if (same) acc[i] = raw[i];
        end
        edges++;
    endtask

    always @(posedge clk) begin
        model_step();
        exp_q.push_back({m_st == M_FAULT, 3'(m_code), m_flash, m_st == M_RUN});
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            check("outputs{fault,code,flash,ok}", {26'd0, fault, fault_code, flash_red, ok}, {26'd0, e});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_lamp(input int which, input int l);
        logic [2:0] v;
        case (l)
            L_RED:   v = 3'b100;
            L_YEL:   v = 3'b010;
            L_GRN:   v = 3'b001;
            default: v = 3'b000;
        endcase
        if (which == 0) {ra, ya, ga} = v;
        else            {rb, yb, gb} = v;
    endtask

    task automatic lamps(input int a, input int b, input int n);
        set_lamp(0, a);
        set_lamp(1, b);
        step(n);
    endtask

    task automatic clear_fault();
        lamps(L_RED, L_RED, 6);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(6);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        {ra, ya, ga, rb, yb, gb} = 6'b0;
        step(3);
        check("reset_fault", {31'd0, fault}, 32'd0);
        check("reset_code", {29'd0, fault_code}, 32'd0);
        check("reset_ok", {31'd0, ok}, 32'd0);

        // Legal two-phase cycle, repeated.
        rst_n = 1'b1;
        en    = 1'b1;
        for (int rep = 0; rep < 4; rep++) begin
            lamps(L_GRN, L_RED, 140);
            lamps(L_YEL, L_RED, 20);
            lamps(L_RED, L_GRN, 100);
            lamps(L_RED, L_YEL, 20);
        end
        lamps(L_GRN, L_RED, 20);
        check("legal_cycle_fault", {31'd0, fault}, 32'd0);
        check("legal_cycle_ok", {31'd0, ok}, 32'd1);

        // Three-cycle conflict excursion is filtered out.
        lamps(L_GRN, L_GRN, 3);
        lamps(L_GRN, L_RED, 10);
        check("glitch3_ok", {31'd0, ok}, 32'd1);

        // Four-cycle conflict is accepted and latched as code 1.
        lamps(L_GRN, L_GRN, 4);
        lamps(L_GRN, L_RED, 2);
        check("conflict_fault", {31'd0, fault}, 32'd1);
        check("conflict_code", {29'd0, fault_code}, 32'd1);
        step(40);

        // Clear refused while approach A shows green.
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(3);
        check("clr_refused", {31'd0, fault}, 32'd1);
        clear_fault();
        check("clr_accepted_fault", {31'd0, fault}, 32'd0);
        check("clr_accepted_ok", {31'd0, ok}, 32'd1);

        // Green straight to red: sequence fault.
        lamps(L_GRN, L_RED, 8);
        lamps(L_RED, L_RED, 8);
        check("seq_code", {29'd0, fault_code}, 32'd3);
        clear_fault();

        // Yellow held for one tick only: short-yellow fault.
        lamps(L_GRN, L_RED, 8);
        lamps(L_YEL, L_RED, 10);
        lamps(L_RED, L_RED, 8);
        check("short_yel_code", {29'd0, fault_code}, 32'd4);
        clear_fault();

        // All lamps dark on A: invalid lamp fault.
        lamps(L_BAD, L_RED, 8);
        check("bad_code", {29'd0, fault_code}, 32'd2);

        // Asynchronous reset inside FAULT.
        rst_n = 1'b0;
        #1;
        check("async_rst_fault", {31'd0, fault}, 32'd0);
        check("async_rst_code", {29'd0, fault_code}, 32'd0);
        check("async_rst_flash", {31'd0, flash_red}, 32'd0);
        step(3);
        rst_n = 1'b1;

        // Disabled: conflicting lamps raise nothing.
        en = 1'b0;
        lamps(L_GRN, L_GRN, 30);
        check("disabled_ok", {31'd0, ok}, 32'd0);
        check("disabled_fault", {31'd0, fault}, 32'd0);

        // Randomised segments.
        for (int s = 0; s < 150; s++) begin
            int x;
            for (int i = 0; i < 2; i++) begin
                x = int'($urandom_range(0, 99));
                if (x < 85) set_lamp(i, int'($urandom_range(0, 2)));
                else if (i == 0) {ra, ya, ga} = 3'($urandom);
                else {rb, yb, gb} = 3'($urandom);
            end
            if ($urandom_range(0, 4) == 0) begin
                set_lamp(0, L_RED);
                set_lamp(1, L_RED);
            end
            en  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
            step(int'($urandom_range(1, 25)));
        end
        clr = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter FINAL_VALUE, 33'd500_000_000, clock cycles per monitor tick (5 s at 100 MHz).
REQ-002 Parameter GLITCH_CYCLES, 4, consecutive cycles a decoded lamp state must hold before acceptance (range 1..15).
REQ-003 Parameter MIN_YELLOW, 2, minimum accepted yellow duration in ticks (range 1..14).
REQ-004 Port clk, input, 1, single clock, rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port enable, input, 1, monitoring active when high.
REQ-007 Ports R_a, Y_a, G_a, input, 1 each, approach A lamp drives under observation.
REQ-008 Ports R_b, Y_b, G_b, input, 1 each, approach B lamp drives under observation.
REQ-009 Port fault_clr, input, 1, request to clear a latched fault.
REQ-010 Port fault, output, 1, latched fault indicator.
REQ-011 Port fault_code, output, 3, cause of the first latched fault.
REQ-012 Port flash_red, output, 1, fail-safe flashing-red drive.
REQ-013 Port ok, output, 1, high when monitoring with no fault.

Function
REQ-014 Each approach's lamps SHALL decode to RED, YEL, GRN (exactly one lamp high) or BAD (zero or more than one lamp high).
REQ-015 A decoded state SHALL be accepted only after GLITCH_CYCLES consecutive identical samples; shorter excursions are ignored.
REQ-016 The tick prescaler SHALL pulse one cycle every FINAL_VALUE cycles, free-running from reset regardless of enable.
REQ-017 The FSM SHALL have states IDLE, SEED, RUN, FAULT; reset enters IDLE.
REQ-018 IDLE -> SEED when enable=1; SEED -> RUN once both approaches have an accepted state; RUN or SEED -> IDLE when enable=0.
REQ-019 The first accepted state per approach in SEED SHALL be stored without sequence checking.
REQ-020 In RUN, accepted A and B both non-RED SHALL latch fault code 3'd1 (conflict).
REQ-021 In RUN, an accepted BAD on either approach SHALL latch code 3'd2 (invalid lamp).
REQ-022 In RUN, accepted transitions other than GRN->YEL, YEL->RED, RED->GRN SHALL latch code 3'd3 (sequence).
REQ-023 A per-approach yellow counter SHALL count ticks while accepted state is YEL, saturating at 15, clearing on entry to YEL.
REQ-024 On YEL->RED with yellow count < MIN_YELLOW, code 3'd4 (short yellow) SHALL latch.
REQ-025 Simultaneous detections SHALL latch the lowest code number; FSM enters FAULT the cycle after detection.
REQ-026 In FAULT, fault=1, fault_code held, ok=0, flash_red toggles on every tick; enable is ignored.
REQ-027 fault_clr in FAULT SHALL be honoured only when both raw approaches decode RED and no conflict exists; then FSM -> SEED, fault=0, fault_code=0, flash_red=0.
REQ-028 fault_clr outside FAULT, or when the REQ-027 condition fails, SHALL have no effect.
REQ-029 ok SHALL be 1 exactly when state is RUN.

Reset
REQ-030 Asserting reset SHALL, asynchronously, set fault=0, fault_code=0, flash_red=0, ok=0, clear filters, prescaler, yellow counters and stored states.
REQ-031 Reset asserted mid-fault or mid-yellow SHALL discard all history; after release, checking restarts via SEED.

Structure
REQ-032 Shared package traffic_pkg SHALL hold lamp-state encoding (RED, YEL, GRN, BAD), fault codes 1..4 and FSM state encoding.
REQ-033 Sub-module lamp_filter (decode + glitch filter for one approach) SHALL be instantiated twice.

Verification
REQ-034 FINAL_VALUE=10, GLITCH_CYCLES=4: legal cycle GA/RB 14 ticks, YA 2 ticks, RA/GB 10 ticks, YB 2 ticks, repeated -> fault stays 0, ok=1 after seeding.
REQ-035 G_a and G_b both high for 4 cycles in RUN -> fault=1, fault_code=1 next cycle, flash_red toggles every 10 cycles.
REQ-036 G_a and G_b both high for 3 cycles only -> no fault, ok stays 1.
REQ-037 Approach A goes GRN->RED directly -> fault_code=3; yellow held 1 tick then RED -> fault_code=4.
REQ-038 In FAULT, fault_clr with G_a high -> ignored; all-red then fault_clr -> fault=0, ok=1 after reseeding.
REQ-039 reset pulsed low during FAULT -> all outputs 0 immediately; enable=0 -> ok=0, no faults on conflicting inputs.
